// File: rtl/soc_pkg.sv
// Shared SoC address map and button-port register constants.
package soc_pkg;

  localparam logic [31:0] LED_ADDR    = 32'h8000_0000;
  localparam logic [31:0] BUTTON_BASE = 32'h8000_0010;

  // Word indices inside the 16-byte button register window
  localparam logic [1:0] BTN_STATE = 2'd0;
  localparam logic [1:0] BTN_RISE  = 2'd1;
  localparam logic [1:0] BTN_FALL  = 2'd2;
  localparam logic [1:0] BTN_DEB   = 2'd3;

  // 1 ms at 25 MHz
  localparam logic [15:0] DEB_DEFAULT = 16'd25000;

endpackage

// File: rtl/btn_debounce.sv
// One button bit: two-flop synchroniser, settle counter and accepted (stable) level.
module btn_debounce #(
  parameter int DEB_W = 16
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             raw,
  input  logic [DEB_W-1:0] limit,
  output logic             stable
);

  logic [1:0]       sync_pipe;
  logic [DEB_W-1:0] cnt;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync_pipe <= '0;
      cnt       <= '0;
      stable    <= 1'b0;
    end else begin
      sync_pipe <= {sync_pipe[0], raw};
      // Any return to the accepted level restarts the settle window
      if (sync_pipe[1] == stable) begin
        cnt <= '0;
      end else if (cnt == limit) begin
        stable <= sync_pipe[1];
        cnt    <= '0;
      end else begin
        cnt <= cnt + DEB_W'(1);
      end
    end
  end

endmodule

// File: rtl/button_port.sv
// Memory-mapped push-button port: debounced state, sticky W1C edge flags, irq.
module button_port
  import soc_pkg::*;
#(
  parameter logic [31:0]      BASE_ADDR = BUTTON_BASE,
  parameter int               N_BTN     = 7,
  parameter int               DEB_W     = 16,
  parameter logic [DEB_W-1:0] DEB_RESET = DEB_W'(DEB_DEFAULT)
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [N_BTN-1:0] btn_raw,
  input  logic [31:0]      mem_address,
  input  logic [31:0]      mem_wdata,
  input  logic             mem_wenable,
  output logic [31:0]      rdata,
  output logic             hit,
  output logic             irq
);

  logic [N_BTN-1:0] stable, stable_d;
  logic [N_BTN-1:0] rise_q, fall_q, rise_nxt, fall_nxt;
  logic [N_BTN-1:0] rise_clr, fall_clr;
  logic [DEB_W-1:0] deb_q;
  logic [31:0]      off;
  logic [1:0]       widx;
  logic             wr;
  logic             unused_bits;

  assign off  = mem_address - BASE_ADDR;
  assign hit  = (off[31:4] == 28'd0);
  assign widx = off[3:2];
  assign wr   = mem_wenable & hit;
  assign unused_bits = ^{off[1:0], mem_wdata};

  for (genvar i = 0; i < N_BTN; i++) begin : g_btn
    btn_debounce #(.DEB_W(DEB_W)) u_deb (
      .clk    (clk),
      .resetn (resetn),
      .raw    (btn_raw[i]),
      .limit  (deb_q),
      .stable (stable[i])
    );
  end

  assign rise_clr = (wr && widx == BTN_RISE) ? mem_wdata[N_BTN-1:0] : '0;
  assign fall_clr = (wr && widx == BTN_FALL) ? mem_wdata[N_BTN-1:0] : '0;

  // Set term is ORed after the clear so a coincident edge wins
  assign rise_nxt = (rise_q & ~rise_clr) | (stable & ~stable_d);
  assign fall_nxt = (fall_q & ~fall_clr) | (~stable & stable_d);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      stable_d <= '0;
      rise_q   <= '0;
      fall_q   <= '0;
      irq      <= 1'b0;
      deb_q    <= DEB_RESET;
    end else begin
      stable_d <= stable;
      rise_q   <= rise_nxt;
      fall_q   <= fall_nxt;
      irq      <= (|rise_nxt) | (|fall_nxt);
      if (wr && widx == BTN_DEB) deb_q <= mem_wdata[DEB_W-1:0];
    end
  end

  always_comb begin
    rdata = '0;
    if (hit) begin
      case (widx)
        BTN_STATE: rdata[N_BTN-1:0] = stable;
        BTN_RISE:  rdata[N_BTN-1:0] = rise_q;
        BTN_FALL:  rdata[N_BTN-1:0] = fall_q;
        BTN_DEB:   rdata[DEB_W-1:0] = deb_q;
      endcase
    end
  end

endmodule

// File: doc/button_port.md
Name: button_port

Overview:
- Memory-mapped input peripheral on the CPU data bus. It is the input-direction counterpart to the LED output register.
- Synchronises and debounces N raw push-button inputs, latches rising and falling edges into sticky write-1-to-clear registers, and serves register reads combinationally.
- The SoC ORs `rdata` into the CPU `mem_rdata_in` path whenever `hit` is high.

Parameters:
- BASE_ADDR, 32'h80000010, word-aligned base of the 16-byte register window.
- N_BTN, 7, number of button inputs (1..32).
- DEB_W, 16, width of the debounce counter and the DEBOUNCE register.
- DEB_RESET, 16'd25000, reset value of the DEBOUNCE register (1 ms at 25 MHz).

Ports:
- clk  in  1  system clock.
- resetn  in  1  asynchronous active-low reset.
- btn_raw  in  N_BTN  raw button pins, asynchronous to clk, active-high.
- mem_address  in  32  CPU data address.
- mem_wdata  in  32  CPU write data.
- mem_wenable  in  1  CPU write strobe, valid for one cycle.
- rdata  out  32  read data, combinational from address and registers.
- hit  out  1  high when mem_address falls in [BASE_ADDR, BASE_ADDR+0xF].
- irq  out  1  high when any pending edge bit is set.

Behaviour:
- Reset: resetn is asynchronous and active-low. While low, all of the following hold:
  - sync flops = 0, stable = 0, counters = 0.
  - RISE = 0, FALL = 0, DEBOUNCE = DEB_RESET.
  - irq = 0; rdata = 0 unless hit.
- Synchroniser: two flops per bit (s1, s2). s2 is the synchronised input. Latency from pin to s2 is 2 cycles.
- Debounce, per bit i:
  - If s2[i] == stable[i]: cnt[i] <= 0.
  - Else if cnt[i] == DEBOUNCE: stable[i] <= s2[i] and cnt[i] <= 0.
  - Else: cnt[i] <= cnt[i] + 1.
  - A change is therefore accepted after s2 has differed from stable for DEBOUNCE+1 consecutive cycles.
  - DEBOUNCE = 0 means accepted on the first differing cycle.
  - Any bounce back to equality restarts the count from 0.
- Edge latch, per bit:
  - RISE[i] sets in the cycle after stable[i] goes 0->1.
  - FALL[i] sets in the cycle after stable[i] goes 1->0.
  - Both bits are sticky until cleared.
- Register map (offset from BASE_ADDR, using mem_address[3:2]):
  - 0x0 STATE: RO. Bits [N_BTN-1:0] = stable, upper bits 0. Writes are ignored.
  - 0x4 RISE: W1C. Writing 1 to bit i clears RISE[i]; writing 0 has no effect.
  - 0x8 FALL: W1C, same rule as RISE.
  - 0xC DEBOUNCE: RW. Bits [DEB_W-1:0]; upper read bits 0. A new value takes effect on the next cycle's compare; counters are not cleared on write.
- Writes take effect on the rising clk edge when mem_wenable && hit.
- Reads:
  - rdata is purely combinational with zero-cycle latency, so the CPU samples it in the same cycle.
  - rdata = 0 when !hit.
  - Reads have no side effects.
- Byte offsets [1:0] are ignored; the access is treated as word-aligned.
- Simultaneous edge and W1C clear on the same bit in the same cycle: set wins, so the bit remains 1.
- irq = |RISE | |FALL, registered, so it follows the pending bits with no extra latency.
- Reset asserted mid-debounce or with edges pending: everything is cleared immediately. After release, a button held high produces a RISE event once debounced, because stable starts at 0.

Decomposition:
- Shared package `soc_pkg` holds:
  - address constants: BUTTON_BASE = 32'h80000010, LED_ADDR = 32'h80000000;
  - offset localparams: BTN_STATE=0, BTN_RISE=1, BTN_FALL=2, BTN_DEB=3 (word indices);
  - the default debounce constant.
- One sub-module, `btn_debounce`: one bit of synchroniser + counter + stable flop, with ports clk, resetn, raw, limit[DEB_W], stable. It is instantiated N_BTN times in a generate loop. Edge logic and the register file stay in button_port.

Test Plan:
1. Reset: hold resetn=0, toggle btn_raw -> STATE/RISE/FALL read 0, DEBOUNCE reads 25000, irq=0. Release -> values unchanged until debounce completes.
2. Clean press: DEBOUNCE=4. Raise btn_raw[0] and hold -> STATE[0]=1 exactly 2+5+1 cycles after the pin edge. RISE reads 0x1 and irq=1 one cycle later.
3. Bounce: DEBOUNCE=4. btn_raw[2] pattern 1,1,1,0,1,1,1,1,1,1 -> counter restarts at the 0. STATE[2] rises only after 5 consecutive synchronised 1s. RISE=0x4 only once.
4. W1C: with RISE=0x5, write 0x1 to BASE+4 -> RISE=0x4, irq stays 1. Write 0x4 -> RISE=0, irq=0 next cycle. Writing to BASE+0 leaves STATE unchanged.
5. Set-beats-clear: schedule the stable 0->1 transition of bit 1 in the same cycle as a W1C write of 0x2 to RISE -> RISE[1]=1 afterwards.
6. Decode: read 0x80000000 and 0x80000020 -> hit=0, rdata=0. Read 0x8000001C -> hit=1, returns DEBOUNCE. Write 0x0000FFFF to DEBOUNCE -> reads back 0xFFFF.
